// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered display value,
// leading-zero blanking, ghost blanking and global enable. Define SEG_SCAN_DP_EN for decimal points.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_blank,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp
`endif
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: CLK_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES > CLK_DIV - 1) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYCLES must be 0..CLK_DIV-1");
  end

  // Active-low segment pattern, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     pend_q, pend_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic [NUM_DIGITS-1:0] disp_dp;

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  dp_q, dp_d;

  assign disp_dp = disp_dp_q;
  assign dp      = dp_q;
`else
  assign disp_dp = '0;
`endif

  logic                  tick;
  logic                  frame_end;
  logic                  in_window;
  logic                  show;
  logic [3:0]            cur_digit;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  upper_set;

  // Ghost blanking: the first BLANK_CYCLES of every slot keep all anodes off.
  if (BLANK_CYCLES == 0) begin : g_no_ghost
    assign in_window = 1'b1;
  end else begin : g_ghost
    assign in_window = (cnt_q >= CNT_W'(BLANK_CYCLES));
  end

  assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];
  assign show      = en && in_window;

  // lz_mask[k] = digit k and every digit above it are zero with no decimal point set.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    lz_mask   = '0;
    upper_set = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_set  = upper_set | (disp_q[4*k +: 4] != 4'h0) | disp_dp[k];
      lz_mask[k] = ~upper_set;
    end
  end

  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // A load on the frame-end edge still lets the old buffered value through.
    pend_d    = load ? data_in : pend_q;
    disp_d    = (frame_end && pending_q) ? pend_q : disp_q;
    pending_d = load ? 1'b1 : (frame_end ? 1'b0 : pending_q);

    frame_done_d = frame_end;

    an_d  = '1;
    seg_d = SEG_OFF;
    if (show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = (lz_blank && lz_mask[idx_q]) ? SEG_OFF : hex_to_seg(cur_digit);
    end
  end

`ifdef SEG_SCAN_DP_EN
  always_comb begin
    pend_dp_d = load ? dp_in : pend_dp_q;
    disp_dp_d = (frame_end && pending_q) ? pend_dp_q : disp_dp_q;
    dp_d      = show ? ~disp_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dp_q <= '0;
      disp_dp_q <= '0;
      dp_q      <= 1'b1;
    end else begin
      pend_dp_q <= pend_dp_d;
      disp_dp_q <= disp_dp_d;
      dp_q      <= dp_d;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a time-based reference model pushes the expected
// outputs every clock edge; a monitor on the falling edge pops and compares.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_blank;
  logic        load;
  logic [15:0] data_in;
  logic        pending;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp_in = '0;
  logic        dp;
`endif

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lz_blank  (lz_blank),
    .load      (load),
    .data_in   (data_in),
    .pending   (pending),
    .frame_done(frame_done),
    .an        (an),
    .seg       (seg)
`ifdef SEG_SCAN_DP_EN
    ,
    .dp_in     (dp_in),
    .dp        (dp)
`endif
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       pending;
    logic       frame_done;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 1'b0;
  logic [6:0]  dec_tab[16];

  // Reference model state: time since reset plus the two value buffers.
  int unsigned t_m;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic        m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot position and digit index derive from elapsed cycles; outputs reflect pre-edge state.
  always @(posedge clk) begin
    obs_t        e;
    int          pos;
    int          k;
    bit          fe;
    logic [15:0] sh;
    if (rst) begin
      t_m       = 0;
      m_pend    = '0;
      m_disp    = '0;
      m_pending = 1'b0;
      e         = '{an: 4'hF, seg: 7'h7F, pending: 1'b0, frame_done: 1'b0};
    end else begin
      pos = int'(t_m % DIV);
      k   = int'((t_m / DIV) % N);
      fe  = (t_m % FRAME) == FRAME - 1;
      if (en && pos >= BLANK) begin
        e.an  = ~(4'(1) << k);
        sh    = m_disp >> (4 * k);
        e.seg = (lz_blank && k > 0 && sh == 16'h0) ? 7'h7F : dec_tab[sh[3:0]];
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end
      e.frame_done = fe;
      if (fe && m_pending) m_disp = m_pend;
      if (load) begin
        m_pend    = data_in;
        m_pending = 1'b1;
      end else if (fe) begin
        m_pending = 1'b0;
      end
      e.pending = m_pending;
      t_m++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e;
    if (!done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("pending", 32'(pending), 32'(e.pending));
      check("frame_done", 32'(frame_done), 32'(e.frame_done));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    data_in = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Wait until the next edge is frame position p; an expired bound is a failed comparison.
  task automatic wait_pos(input int p);
    int i;
    i = 0;
    while (int'(t_m % FRAME) != p && i < 2 * FRAME) begin
      @(negedge clk);
      i++;
    end
    check("frame_align", 32'(t_m % FRAME), 32'(p));
  endtask

  initial begin
    dec_tab  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst      = 1'b1;
    en       = 1'b1;
    lz_blank = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    cycles(2);
    rst = 1'b0;
    cycles(40);

    // Mid-frame load appears only after the next frame boundary.
    wait_pos(13);
    do_load(16'h1234);
    cycles(70);

    lz_blank = 1'b1;
    do_load(16'h0050);
    cycles(70);
    do_load(16'h0000);
    cycles(70);
    lz_blank = 1'b0;

    // Two loads in one frame: the last one wins.
    wait_pos(2);
    do_load(16'hAAAA);
    cycles(5);
    do_load(16'hBEEF);
    cycles(70);

    // Load coinciding with the frame-end tick while nothing is pending.
    wait_pos(FRAME - 1);
    do_load(16'h5555);
    cycles(70);

    // Random loads, enable and blanking toggles.
    for (int i = 0; i < 800; i++) begin
      load    = ($urandom_range(0, 11) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 4) == 0) data_in[15:8] = 8'h00;
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
      @(negedge clk);
    end
    load     = 1'b0;
    en       = 1'b1;
    lz_blank = 1'b0;
    do_load(16'h9876);

    // Reset mid-slot, with a value pending, restarts the scan from a blank display.
    wait_pos(DIV + 5);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(45);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode 7-segment display; successor to the single-digit combinational hex decoder.
- Scans one digit per slot, double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Adds leading-zero blanking, inter-digit ghost blanking and a global enable.
- Sits between the core's value registers and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (0 .. CLK_DIV-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = display on; 0 = anodes and segments off, scan keeps running.
- lz_blank  in  1  1 = blank leading-zero digits.
- load  in  1  single-cycle strobe; captures data_in.
- data_in  in  4*NUM_DIGITS  hex digits; digit k = data_in[4k+3:4k], digit 0 rightmost.
- pending  out  1  loaded value waiting for frame boundary.
- frame_done  out  1  one-cycle pulse at each frame wrap.
- an  out  NUM_DIGITS  anode enables, active low, an[k] selects digit k.
- seg  out  7  segments, active low, seg[0]=a .. seg[6]=g.

Behaviour:
- Reset (clk edge with rst=1): cnt=0, idx=0, pend_reg=0, disp_reg=0, pending=0, frame_done=0, an=all 1s, seg=7'h7F. rst has priority over all inputs, including mid-frame.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- Digit index: idx advances on tick and wraps NUM_DIGITS-1 -> 0. Width is clog2(NUM_DIGITS), minimum 1.
- Frame end: tick with idx==NUM_DIGITS-1.
  - Next cycle, frame_done=1 for exactly one cycle.
  - If pending=1: disp_reg <= pend_reg and pending <= 0.
- Load:
  - load=1 sets pend_reg <= data_in and pending <= 1.
  - A second load before frame end overwrites pend_reg; last wins.
  - Load coinciding with frame end: disp_reg takes the OLD pend_reg (only if pending was 1); pend_reg takes the new data; pending stays or becomes 1.
- Decode (active low, g..a), hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (lz_blank=1): digit k>0 is blanked (seg=7F) when it and all higher digits of disp_reg are 0. Digit 0 is never blanked.
- Outputs registered, 1-cycle latency from (cnt, idx) state:
  - an = ~(1<<idx) and seg = decode(disp_reg digit idx) when en=1 and cnt>=BLANK_CYCLES.
  - Otherwise an=all 1s and seg=7F.
- en affects outputs only: cnt, idx and buffering continue regardless.
- lz_blank and en are sampled every cycle; no frame alignment.

Optional Feature:
- Macro SEG_SCAN_DP_EN.
- Defined:
  - Adds input dp_in[NUM_DIGITS-1:0] and output dp (active low).
  - dp_in is buffered alongside data_in through pend_reg/disp_reg.
  - dp = ~disp_dp[idx] under the same blank/en gating as seg.
  - A set dp bit prevents leading-zero blanking of that digit and all digits below it.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2):
- Reset, en=1, hold 40 cycles -> an cycles 1110,1101,1011,0111 showing seg=40 each; an=F during first 2 cycles of each slot; frame_done every 32 cycles.
- load data_in=16'h1234 mid-frame -> pending=1; unchanged display until frame_done; next frame digit0 seg=19, d1=30, d2=24, d3=79; pending=0.
- lz_blank=1, data_in=16'h0050 -> d0=40, d1=12, d2/d3 an low but seg=7F; data_in=16'h0000 -> only d0 shows 40.
- Two loads (16'hAAAA then 16'hBEEF) in one frame -> next frame shows BEEF: d0=0E, d1=06, d2=06, d3=03.
- load 16'h5555 on the frame-end tick with pending=0 -> display unchanged that frame, pending=1, shows 5555 (seg=12) one frame later.
- rst asserted mid-slot with en=1 -> next cycle an=F, seg=7F, pending=0; scan restarts at idx 0 with disp=0.
